// File: rtl/square_motion_ctrl_if.sv
// Frame-control and position bus between frame-timing/collision logic
// (master) and one object's motion sequencer (slave).
//   enable       : level, run motion when 1
//   startOfFrame : one-cycle pulse per VGA frame
//   collision    : level, object overlaps another object this cycle
//   topLeftX/Y   : current top-left corner, signed pixels
//   frozen       : high while the object is held after a hit
//   hitPulse     : one-cycle pulse when a collision is acted on
interface square_motion_ctrl_if;
  localparam int unsigned POS_W = 11;

  logic                    enable;
  logic                    startOfFrame;
  logic                    collision;
  logic signed [POS_W-1:0] topLeftX;
  logic signed [POS_W-1:0] topLeftY;
  logic                    frozen;
  logic                    hitPulse;

  modport master (
    output enable, startOfFrame, collision,
    input  topLeftX, topLeftY, frozen, hitPulse
  );

  modport slave (
    input  enable, startOfFrame, collision,
    output topLeftX, topLeftY, frozen, hitPulse
  );
endinterface

// File: rtl/square_motion_ctrl.sv
// Per-frame position sequencer for one rectangular VGA object. Moves the
// top-left corner by a signed velocity on each startOfFrame, clamps and
// bounces at the screen limits, reverses on a collision and then freezes
// for HIT_FREEZE_FRAMES frames.
//   clk   : system clock
//   reset : synchronous, active-high
//   bus   : square_motion_ctrl_if.slave (controls in, position/status out)
module square_motion_ctrl #(
  parameter int INIT_X            = 280,
  parameter int INIT_Y            = 200,
  parameter int INIT_VX           = 2,
  parameter int INIT_VY           = 1,
  parameter int OBJECT_WIDTH_X    = 11,
  parameter int OBJECT_HEIGHT_Y   = 48,
  parameter int MIN_X             = 0,
  parameter int MAX_X             = 639,
  parameter int MIN_Y             = 0,
  parameter int MAX_Y             = 479,
  parameter int HIT_FREEZE_FRAMES = 8
) (
  input logic                 clk,
  input logic                 reset,
  square_motion_ctrl_if.slave bus
);

  localparam int unsigned POS_W  = 11;
  localparam int unsigned VEL_W  = 5;
  localparam int unsigned CALC_W = 13;
  localparam int unsigned CNT_W  = $clog2(HIT_FREEZE_FRAMES + 1);

  typedef enum logic [1:0] {IDLE, RUN, FREEZE} state_t;

  state_t                  state, state_n;
  logic signed [POS_W-1:0] x, x_n, y, y_n;
  logic signed [VEL_W-1:0] vx, vx_n, vy, vy_n;
  logic [CNT_W-1:0]        cnt, cnt_n;
  logic                    latch, latch_n;
  logic                    frozen, frozen_n;
  logic                    hit, hit_n;
  logic [POS_W:0]          step_x, step_y;

  // One axis move: returns {reverse_velocity, new_position}. Landing exactly
  // on a limit is legal; only overshoot clamps and reverses.
  function automatic logic [POS_W:0] axis_step(
    input logic signed [POS_W-1:0] pos,
    input logic signed [VEL_W-1:0] vel,
    input int                      lo,
    input int                      hi,
    input int                      size
  );
    logic signed [CALC_W-1:0] np;
    logic signed [CALC_W-1:0] lo_c;
    logic signed [CALC_W-1:0] hi_c;
    np   = CALC_W'(pos) + CALC_W'(vel);
    lo_c = CALC_W'(lo);
    hi_c = CALC_W'(hi - size + 1);
    if (np < lo_c) begin
      return {1'b1, POS_W'(lo_c)};
    end else if (np > hi_c) begin
      return {1'b1, POS_W'(hi_c)};
    end
    return {1'b0, POS_W'(np)};
  endfunction

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      x      <= POS_W'(INIT_X);
      y      <= POS_W'(INIT_Y);
      vx     <= VEL_W'(INIT_VX);
      vy     <= VEL_W'(INIT_VY);
      cnt    <= '0;
      latch  <= 1'b0;
      frozen <= 1'b0;
      hit    <= 1'b0;
    end else begin
      state  <= state_n;
      x      <= x_n;
      y      <= y_n;
      vx     <= vx_n;
      vy     <= vy_n;
      cnt    <= cnt_n;
      latch  <= latch_n;
      frozen <= frozen_n;
      hit    <= hit_n;
    end
  end

  // Next-state, motion and status logic
  always_comb begin
    state_n = state;
    x_n     = x;
    y_n     = y;
    vx_n    = vx;
    vy_n    = vy;
    cnt_n   = cnt;
    latch_n = latch;
    hit_n   = 1'b0;
    step_x  = axis_step(x, vx, MIN_X, MAX_X, OBJECT_WIDTH_X);
    step_y  = axis_step(y, vy, MIN_Y, MAX_Y, OBJECT_HEIGHT_Y);

    case (state)
      IDLE: begin
        latch_n = 1'b0;
        cnt_n   = '0;
        if (bus.enable) state_n = RUN;
      end
      RUN: begin
        if (!bus.enable) begin
          state_n = IDLE;
          cnt_n   = '0;
          latch_n = 1'b0;
        end else if (bus.startOfFrame) begin
          latch_n = 1'b0;
          // A collision on the SOF cycle itself counts for this frame.
          if (latch || bus.collision) begin
            vx_n    = -vx;
            vy_n    = -vy;
            cnt_n   = CNT_W'(HIT_FREEZE_FRAMES);
            hit_n   = 1'b1;
            state_n = FREEZE;
          end else begin
            x_n = signed'(step_x[POS_W-1:0]);
            y_n = signed'(step_y[POS_W-1:0]);
            if (step_x[POS_W]) vx_n = -vx;
            if (step_y[POS_W]) vy_n = -vy;
          end
        end else if (bus.collision) begin
          latch_n = 1'b1;
        end
      end
      FREEZE: begin
        latch_n = 1'b0;
        if (!bus.enable) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (bus.startOfFrame) begin
          cnt_n = cnt - CNT_W'(1);
          // The releasing SOF does not move; motion resumes on the next one.
          if (cnt == CNT_W'(1)) state_n = RUN;
        end
      end
      default: state_n = IDLE;
    endcase

    frozen_n = (state_n == FREEZE);
  end

  assign bus.topLeftX = x;
  assign bus.topLeftY = y;
  assign bus.frozen   = frozen;
  assign bus.hitPulse = hit;

endmodule

// File: tb/tb_square_motion_ctrl.sv
// Directed bench for square_motion_ctrl: default-parameter instance for the
// motion/collision/enable/reset sequences, plus two edge instances started
// next to the right/bottom and left limits for clamp and bounce behaviour.
module tb_square_motion_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en = 1'b0;
  logic sof = 1'b0;
  logic col = 1'b0;
  logic sof_e = 1'b0;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  square_motion_ctrl_if m_if ();
  square_motion_ctrl_if e_if ();
  square_motion_ctrl_if l_if ();

  assign m_if.enable       = en;
  assign m_if.startOfFrame = sof;
  assign m_if.collision    = col;
  assign e_if.enable       = 1'b1;
  assign e_if.startOfFrame = sof_e;
  assign e_if.collision    = 1'b0;
  assign l_if.enable       = 1'b1;
  assign l_if.startOfFrame = sof_e;
  assign l_if.collision    = 1'b0;

  square_motion_ctrl dut (.clk(clk), .reset(rst), .bus(m_if.slave));

  square_motion_ctrl #(.INIT_X(627), .INIT_Y(430)) dut_e (
    .clk(clk), .reset(rst), .bus(e_if.slave));

  square_motion_ctrl #(.INIT_X(4), .INIT_VX(-2), .INIT_Y(5), .INIT_VY(0)) dut_l (
    .clk(clk), .reset(rst), .bus(l_if.slave));

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sof_pulse();
    sof = 1'b1;
    tick();
    sof = 1'b0;
  endtask

  task automatic check_main(input string tag, input int ex, input int ey,
                            input int efz, input int ehit);
    check({tag, ".x"},      int'(m_if.topLeftX), ex);
    check({tag, ".y"},      int'(m_if.topLeftY), ey);
    check({tag, ".frozen"}, int'(m_if.frozen), efz);
    check({tag, ".hit"},    int'(m_if.hitPulse), ehit);
  endtask

  initial begin
    // Reset values
    tick();
    tick();
    rst = 1'b0;
    check_main("reset", 280, 200, 0, 0);

    // Three frames of free motion
    en = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      sof_pulse();
      tick();
    end
    check_main("run3", 286, 203, 0, 0);

    // Collision mid-frame, acted on at the next SOF
    col = 1'b1;
    tick();
    col = 1'b0;
    tick();
    sof_pulse();
    check_main("hit_mid", 286, 203, 1, 1);
    tick();
    check_main("hit_mid_next", 286, 203, 1, 0);
    for (int i = 1; i <= 8; i++) begin
      if (i == 4) begin
        col = 1'b1;   // ignored while frozen
        tick();
        col = 1'b0;
      end
      sof_pulse();
      check($sformatf("frz%0d.frozen", i), int'(m_if.frozen), (i < 8) ? 1 : 0);
      tick();
    end
    check_main("frz_release", 286, 203, 0, 0);
    sof_pulse();
    check_main("resume_rev", 284, 202, 0, 0);
    tick();

    // Collision on the SOF cycle itself
    col = 1'b1;
    sof_pulse();
    col = 1'b0;
    check_main("hit_same", 284, 202, 1, 1);
    for (int i = 1; i <= 8; i++) begin
      sof_pulse();
      tick();
    end
    check_main("same_release", 284, 202, 0, 0);
    sof_pulse();
    check_main("same_resume", 286, 203, 0, 0);
    tick();

    // Disable on an SOF cycle, SOFs ignored in IDLE, re-enable resumes
    en = 1'b0;
    sof_pulse();
    check_main("dis_sof", 286, 203, 0, 0);
    tick();
    sof_pulse();
    tick();
    sof_pulse();
    check_main("idle_sofs", 286, 203, 0, 0);
    en = 1'b1;
    tick();
    sof_pulse();
    check_main("reenable", 288, 204, 0, 0);
    tick();

    // Reset while frozen with counter at 5
    col = 1'b1;
    sof_pulse();
    col = 1'b0;
    check_main("hit6", 288, 204, 1, 1);
    for (int i = 0; i < 3; i++) begin
      sof_pulse();
      tick();
    end
    check("frz5.frozen", int'(m_if.frozen), 1);
    rst = 1'b1;
    sof = 1'b1;
    col = 1'b1;
    tick();
    check_main("rst_frz", 280, 200, 0, 0);
    rst = 1'b0;
    col = 1'b0;
    tick();                 // IDLE -> RUN, SOF ignored
    sof = 1'b0;
    check_main("post_rst_idle", 280, 200, 0, 0);
    sof_pulse();
    check_main("post_rst_move", 282, 201, 0, 0);
    tick();

    // Edge instances: right/bottom exact landing then clamp, left likewise
    begin
      int ex[4] = '{629, 629, 627, 625};
      int ey[4] = '{431, 432, 432, 431};
      int lx[4] = '{2, 0, 0, 2};
      for (int i = 0; i < 4; i++) begin
        sof_e = 1'b1;
        tick();
        sof_e = 1'b0;
        check($sformatf("edge%0d.x", i), int'(e_if.topLeftX), ex[i]);
        check($sformatf("edge%0d.y", i), int'(e_if.topLeftY), ey[i]);
        check($sformatf("left%0d.x", i), int'(l_if.topLeftX), lx[i]);
        check($sformatf("left%0d.y", i), int'(l_if.topLeftY), 5);
        tick();
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
